// File: rtl/channel_done_collector_pkg.sv
// Channel definitions shared by the trigger fan-out and its done-collection return path.
package channel_done_collector_pkg;

  localparam int N_CHAN                 = 5;
  localparam int TIMEOUT_CYCLES_DEFAULT = 50000;
  localparam int CNT_W_DEFAULT          = 16;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  typedef logic [N_CHAN-1:0] chan_mask_t;

endpackage

// File: rtl/channel_done_collector_event_timer.sv
// Response-window counter: counts WAIT cycles since trigger acceptance and flags the last allowed one.
module channel_done_collector_event_timer #(
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         count <= '0;
    else if (clear)  count <= '0;
    else if (enable) count <= count + CNT_W'(1);
  end

  assign expire = (count == LAST);

endmodule

// File: rtl/channel_done_collector.sv
// Collects per-channel done pulses after each trigger and returns one all_done (or timeout) per event.
module channel_done_collector
  import channel_done_collector_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
  parameter int CNT_W          = CNT_W_DEFAULT
) (
  input  logic              ipb_clk,
  input  logic              rst,
  input  logic              trigger_in,
  input  logic [N_CHAN-1:0] chan_enable,
  input  logic [N_CHAN-1:0] chan_done,
  output logic              busy,
  output logic              all_done,
  output logic              timeout_err,
  output logic              retrig_err,
  output logic [N_CHAN-1:0] missing_chans,
  output logic [CNT_W-1:0]  event_count
);

  logic [0:0] state;
  chan_mask_t active_mask;
  chan_mask_t done_seen;
  chan_mask_t done_now;
  logic       accept;
  logic       complete;
  logic       in_wait;
  logic       expire;

  // Include this cycle's dones so a final pulse closes the event on the edge that samples it.
  assign done_now = done_seen | (chan_done & active_mask);
  assign complete = (done_now == active_mask);
  assign in_wait  = (state == ST_WAIT);
  assign accept   = (state == ST_IDLE) && trigger_in && (chan_enable != '0);

  channel_done_collector_event_timer #(
    .CNT_W          (CNT_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_event_timer (
    .clk    (ipb_clk),
    .rst    (rst),
    .clear  (accept),
    .enable (in_wait),
    .expire (expire)
  );

  always_ff @(posedge ipb_clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      busy          <= 1'b0;
      all_done      <= 1'b0;
      timeout_err   <= 1'b0;
      retrig_err    <= 1'b0;
      missing_chans <= '0;
      event_count   <= '0;
      active_mask   <= '0;
      done_seen     <= '0;
    end else begin
      // NOTE: pulse outputs default low each edge and are raised only by the branch that fires them.
      all_done    <= 1'b0;
      timeout_err <= 1'b0;
      retrig_err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            active_mask   <= chan_enable;
            done_seen     <= '0;
            missing_chans <= '0;
            busy          <= 1'b1;
            state         <= ST_WAIT;
          end else if (trigger_in) begin
            all_done      <= 1'b1;
            missing_chans <= '0;
            event_count   <= event_count + CNT_W'(1);
          end
        end
        default: begin
          done_seen  <= done_now;
          retrig_err <= trigger_in;
          if (complete) begin
            all_done    <= 1'b1;
            busy        <= 1'b0;
            event_count <= event_count + CNT_W'(1);
            state       <= ST_IDLE;
          end else if (expire) begin
            timeout_err   <= 1'b1;
            busy          <= 1'b0;
            missing_chans <= active_mask & ~done_now;
            event_count   <= event_count + CNT_W'(1);
            state         <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule
